// File: rtl/decoder_scan_pkg.sv
// Shared types and the per-bit one-hot helper for the scanned SEL_W-to-2^SEL_W decoder.
package decoder_scan_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2,
    ST_BLANK  = 2'd3
  } state_e;

  // Level of output bit idx when channel sel is selected, honouring polarity.
  function automatic logic onehot(input int sel, input int idx, input logic active_low);
    return (sel == idx) ^ active_low;
  endfunction

endpackage

// File: rtl/decoder_scan_nto2n_divider.sv
// Dwell divider for scan mode: tick pulses once every max(period,1) cycles while run is high.
module scan_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] eff_m1;

  // >= rather than == so a period shortened mid-count fires on the next edge.
  assign eff_m1 = (period == '0) ? '0 : period - 1'b1;
  assign tick   = run && (cnt_q >= eff_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/decoder_scan_nto2n.sv
// Registered one-hot select decoder with direct and self-scanning modes.
// Optional inter-channel blanking is built when DECODER_BLANK_EN is defined.
module decoder_scan_nto2n
  import decoder_scan_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int ACTIVE_LOW = 0,
  parameter int DIV_W      = 16,
  parameter int BLANK_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  sel_valid,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic [DIV_W-1:0]      period,
  output logic [(1<<SEL_W)-1:0] dec_out,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  scan_wrap,
  output logic                  blank,
  output state_e                state
);

  // Handshake: sel_valid is a single-cycle strobe sampled on the rising edge;
  // there is no back-pressure, so a strobe is either consumed or ignored.

  localparam int OUT_N = 1 << SEL_W;
  localparam logic [OUT_N-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {OUT_N{1'b1}} : {OUT_N{1'b0}};

  function automatic logic [OUT_N-1:0] decode(input logic [SEL_W-1:0] s);
    logic [OUT_N-1:0] v;
    for (int i = 0; i < OUT_N; i++) begin
      v[i] = onehot(int'(s), i, ACTIVE_LOW != 0);
    end
    return v;
  endfunction

  state_e           req_st;
  state_e           state_d;
  logic [SEL_W-1:0] sel_d;
  logic [OUT_N-1:0] dec_d;
  logic             wrap_d;
  logic             run;
  logic             clr;
  logic             tick;

  // Requested mode is re-derived from en/mode on every edge.
  always_comb begin
    req_st = ST_IDLE;
    if (en) begin
      req_st = (mode_e'(mode) == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
    end
  end

  // The divider freezes (neither runs nor clears) while blanking.
  always_comb begin
    run = (req_st == ST_SCAN) && (state != ST_BLANK);
    clr = (req_st != ST_SCAN) && (state != ST_BLANK);
  end

  scan_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .clr    (clr),
    .period (period),
    .tick   (tick)
  );

`ifdef DECODER_BLANK_EN
  localparam int BLANK_N = (BLANK_CYC < 1) ? 1 : BLANK_CYC;
  localparam int BCW     = (BLANK_N > 1) ? $clog2(BLANK_N) : 1;

  logic           blank_d;
  logic [BCW-1:0] bcnt_q;
  logic [BCW-1:0] bcnt_d;
  logic           switch_ch;
`endif

  always_comb begin
    state_d = req_st;
    sel_d   = cur_sel;
    dec_d   = dec_out;
    wrap_d  = 1'b0;
    case (req_st)
      ST_DIRECT: begin
        if (sel_valid) begin
          sel_d = sel_in;
        end
        dec_d = decode(sel_d);
      end
      ST_SCAN: begin
        if (tick) begin
          sel_d  = cur_sel + 1'b1;
          wrap_d = &cur_sel;
        end
        dec_d = decode(sel_d);
      end
      default: begin
        dec_d = INACTIVE;
      end
    endcase
`ifdef DECODER_BLANK_EN
    blank_d   = blank;
    bcnt_d    = bcnt_q;
    switch_ch = ((req_st == ST_DIRECT) && sel_valid && (sel_in != cur_sel)) ||
                ((req_st == ST_SCAN) && tick);
    if (switch_ch) begin
      state_d = ST_BLANK;
      dec_d   = INACTIVE;
      blank_d = 1'b1;
      bcnt_d  = BCW'(BLANK_N - 1);
    end
    // Blanking runs to completion regardless of en/mode/sel_valid.
    if (state == ST_BLANK) begin
      state_d = req_st;
      sel_d   = cur_sel;
      dec_d   = decode(cur_sel);
      wrap_d  = 1'b0;
      blank_d = 1'b0;
      bcnt_d  = bcnt_q;
      if (bcnt_q != '0) begin
        state_d = ST_BLANK;
        dec_d   = INACTIVE;
        blank_d = 1'b1;
        bcnt_d  = bcnt_q - 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur_sel   <= '0;
      dec_out   <= INACTIVE;
      scan_wrap <= 1'b0;
    end else begin
      state     <= state_d;
      cur_sel   <= sel_d;
      dec_out   <= dec_d;
      scan_wrap <= wrap_d;
    end
  end

`ifdef DECODER_BLANK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank  <= 1'b0;
      bcnt_q <= '0;
    end else begin
      blank  <= blank_d;
      bcnt_q <= bcnt_d;
    end
  end
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Directed bench for decoder_scan_nto2n: one active-high and one active-low instance share stimulus.
module tb_decoder_scan_nto2n;
  import decoder_scan_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic        sel_valid;
  logic [1:0]  sel_in;
  logic [15:0] period;

  logic [3:0]  dec_hi, dec_lo;
  logic [1:0]  sel_hi, sel_lo;
  logic        wrap_hi, wrap_lo;
  logic        blank_hi, blank_lo;
  state_e      state_hi, state_lo;

  int checks = 0;
  int errors = 0;

  decoder_scan_nto2n #(.SEL_W(2), .ACTIVE_LOW(0), .DIV_W(16), .BLANK_CYC(2)) u_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid),
    .sel_in(sel_in), .period(period), .dec_out(dec_hi), .cur_sel(sel_hi),
    .scan_wrap(wrap_hi), .blank(blank_hi), .state(state_hi)
  );

  decoder_scan_nto2n #(.SEL_W(2), .ACTIVE_LOW(1), .DIV_W(16), .BLANK_CYC(2)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid),
    .sel_in(sel_in), .period(period), .dec_out(dec_lo), .cur_sel(sel_lo),
    .scan_wrap(wrap_lo), .blank(blank_lo), .state(state_lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       mode;
    logic       sel_valid;
    logic [1:0] sel_in;
    logic [3:0] exp_dec;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [1:0] es, input logic [3:0] ed,
                         input logic ew, input logic eb);
    logic [3:0] edn;
    edn = ~ed;
    check({name, " dec"},   {28'd0, dec_hi}, {28'd0, ed});
    check({name, " dec_n"}, {28'd0, dec_lo}, {28'd0, edn});
    check({name, " sel"},   {30'd0, sel_hi}, {30'd0, es});
    check({name, " sel_n"}, {30'd0, sel_lo}, {30'd0, es});
    check({name, " wrap"},  {31'd0, wrap_hi}, {31'd0, ew});
    check({name, " blank"}, {31'd0, blank_hi}, {31'd0, eb});
  endtask

  function automatic logic [3:0] oh(input int s);
    return 4'b0001 << s;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic m, input logic v, input logic [1:0] s);
    en        = e;
    mode      = m;
    sel_valid = v;
    sel_in    = s;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    period = 16'd3;
    repeat (2) step();
    chk_out("reset", 2'd0, 4'b0000, 1'b0, 1'b0);
    check("reset state", {30'd0, state_hi}, {30'd0, ST_IDLE});
    rst_n = 1'b1;
  endtask

  task automatic run_default_tests();
    // direct-mode table, including en drop/resume
    vecs[0] = '{1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd2};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 2'd1, 4'b0100, 2'd2};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd3};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 2'd3};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd3};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b1000, 2'd3};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 2'd1, 4'b0010, 2'd1};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd3};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 2'd0};
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].en, vecs[i].mode, vecs[i].sel_valid, vecs[i].sel_in);
      step();
      chk_out($sformatf("dir%0d", i), vecs[i].exp_sel, vecs[i].exp_dec, 1'b0, 1'b0);
    end

    // scan, period 3, from channel 0: advance every third edge, wrap after 3->0
    period = 16'd3;
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    for (int k = 1; k <= 14; k++) begin
      logic [1:0] es;
      es = 2'((k / 3) % 4);
      step();
      chk_out($sformatf("scan3_%0d", k), es, oh(int'(es)), (k == 12), 1'b0);
    end
    check("scan state", {30'd0, state_hi}, {30'd0, ST_SCAN});

    // period 0 behaves as 1
    period = 16'd0;
    for (int j = 1; j <= 5; j++) begin
      logic [1:0] es;
      es = 2'(j % 4);
      step();
      chk_out($sformatf("scan0_%0d", j), es, oh(int'(es)), (j == 4), 1'b0);
    end

    // period 10, sel_valid strobes ignored, then shorten mid-count
    period = 16'd10;
    for (int j = 1; j <= 6; j++) begin
      drive(1'b1, 1'b1, j[0], 2'd3);
      step();
      chk_out($sformatf("scan10_%0d", j), 2'd1, 4'b0010, 1'b0, 1'b0);
    end
    period = 16'd4;
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    step();
    chk_out("shorten", 2'd2, 4'b0100, 1'b0, 1'b0);
    for (int j = 1; j <= 4; j++) begin
      logic [1:0] es;
      es = (j == 4) ? 2'd3 : 2'd2;
      step();
      chk_out($sformatf("scan4_%0d", j), es, oh(int'(es)), 1'b0, 1'b0);
    end

    // scan -> direct holds channel
    drive(1'b1, 1'b0, 1'b0, 2'd1);
    repeat (2) begin
      step();
      chk_out("hold", 2'd3, 4'b1000, 1'b0, 1'b0);
    end

    // re-enter scan with a simultaneous strobe: mode wins, period 1 advances at once
    period = 16'd1;
    drive(1'b1, 1'b1, 1'b1, 2'd2);
    step();
    chk_out("reenter", 2'd0, 4'b0001, 1'b1, 1'b0);

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 2'd0, 4'b0000, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_blank_tests();
    // direct 0->1 then 1->2, two blank cycles each
    logic [1:0] bs[8];
    logic [3:0] bd[8];
    logic       bb[8];
    logic       bw[8];
    drive(1'b1, 1'b0, 1'b1, 2'd1);
    step();
    chk_out("blk_d1a", 2'd1, 4'b0000, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd3);
    step();
    chk_out("blk_d1b", 2'd1, 4'b0000, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 2'd0);
    step();
    chk_out("blk_d1c", 2'd1, 4'b0010, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 2'd2);
    step();
    chk_out("blk_d2a", 2'd2, 4'b0000, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 2'd0);
    step();
    chk_out("blk_d2b", 2'd2, 4'b0000, 1'b0, 1'b1);
    step();
    chk_out("blk_d2c", 2'd2, 4'b0100, 1'b0, 1'b0);

    // scan period 3 with blanking: 5-cycle channel period
    bs = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    bd = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
    bb = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    period = 16'd3;
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk_out($sformatf("blk_s%0d", k), bs[k], bd[k], bw[k], bb[k]);
    end

    #2;
    rst_n = 1'b0;
    #1;
    chk_out("blk_rst", 2'd0, 4'b0000, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
`ifdef DECODER_BLANK_EN
    run_blank_tests();
`else
    run_default_tests();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
